uart_apb: RTL and testbench

UART peripheral on an APB slave port: 8N1 transmitter and receiver with 16-entry TX and RX FIFOs, a programmable baud prescaler, and a masked, level-sensitive interrupt. It sits on the SoC peripheral bus as the instance `dut`. The serial engine is a core submodule instance named `instance_to_wrap` that exposes single-cycle `tx_done` and `rx_done` pulses for bench probing.

---
 rtl/uart_apb.sv | 338 +++++++++++++++++++++++++++++++++
 tb/tb_uart_apb.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_apb.sv
// APB-attached 8N1 UART: 16-deep TX/RX FIFOs, programmable baud prescaler,
// sticky raw interrupt flags with mask and write-1-to-clear.

module uart_fifo (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o,
  output logic [4:0] level_o
);
  logic [7:0] mem_q [16];
  logic [3:0] wptr_q, rptr_q;
  logic [4:0] level_q, level_d;
  logic       do_push, do_pop;

  // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
  assign do_pop  = pop_i & (level_q != 5'd0);
  assign do_push = push_i & ((level_q != 5'd16) | do_pop);

  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop) level_d = level_q + 5'd1;
    if (do_pop && !do_push) level_d = level_q - 5'd1;
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 4'd1;
      if (do_pop)  rptr_q <= rptr_q + 4'd1;
      level_q <= level_d;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign level_o = level_q;
endmodule

module uart_core (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        txen_i,
  input  logic        rxen_i,
  input  logic [15:0] pr_i,
  input  logic        tx_empty_i,
  input  logic [7:0]  tx_data_i,
  input  logic        rx_i,
  output logic        tx_o,
  output logic        tx_pop_o,
  output logic        tx_done,
  output logic        rx_done,
  output logic        rx_fe_o,
  output logic [7:0]  rx_data_o
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e      tx_st_q;
  logic [15:0] tx_pres_q;
  logic [3:0]  tx_tcnt_q;
  logic [2:0]  tx_bit_q;
  logic [7:0]  tx_sh_q;
  logic        tx_q, tx_done_q;
  logic        tx_tick, tx_bit_end, tx_go;

  // Each side keeps its own prescaler, restarted when a frame begins, so bit
  // boundaries are aligned to the frame rather than to a free-running tick.
  assign tx_tick    = (tx_pres_q >= pr_i);
  assign tx_bit_end = tx_tick && (tx_tcnt_q == 4'd15);
  assign tx_go      = en_i & txen_i & ~tx_empty_i;
  assign tx_pop_o   = tx_go & ((tx_st_q == S_IDLE) | ((tx_st_q == S_STOP) & tx_bit_end));

  always_ff @(posedge clk_i) begin
    if (!rst_ni || !en_i) begin
      tx_st_q   <= S_IDLE;
      tx_q      <= 1'b1;
      tx_done_q <= 1'b0;
      tx_pres_q <= '0;
      tx_tcnt_q <= '0;
      tx_bit_q  <= '0;
    end else begin
      tx_done_q <= 1'b0;
      tx_pres_q <= (tx_st_q == S_IDLE || tx_tick) ? 16'd0 : tx_pres_q + 16'd1;
      if (tx_st_q != S_IDLE && tx_tick) tx_tcnt_q <= tx_tcnt_q + 4'd1;
      case (tx_st_q)
        S_IDLE: begin
          if (tx_pop_o) begin
            tx_st_q   <= S_START;
            tx_q      <= 1'b0;
            tx_tcnt_q <= '0;
            tx_sh_q   <= tx_data_i;
          end
        end
        S_START: begin
          if (tx_bit_end) begin
            tx_st_q  <= S_DATA;
            tx_q     <= tx_sh_q[0];
            tx_bit_q <= '0;
          end
        end
        S_DATA: begin
          if (tx_bit_end) begin
            tx_sh_q <= {1'b0, tx_sh_q[7:1]};
            if (tx_bit_q == 3'd7) begin
              tx_st_q <= S_STOP;
              tx_q    <= 1'b1;
            end else begin
              tx_bit_q <= tx_bit_q + 3'd1;
              tx_q     <= tx_sh_q[1];
            end
          end
        end
        S_STOP: begin
          if (tx_bit_end) begin
            tx_done_q <= 1'b1;
            if (tx_pop_o) begin
              tx_st_q <= S_START;
              tx_q    <= 1'b0;
              tx_sh_q <= tx_data_i;
            end else begin
              tx_st_q <= S_IDLE;
            end
          end
        end
        default: tx_st_q <= S_IDLE;
      endcase
    end
  end

  assign tx_o    = tx_q;
  assign tx_done = tx_done_q;

  state_e      rx_st_q;
  logic [2:0]  rx_sync_q;
  logic [15:0] rx_pres_q;
  logic [3:0]  rx_tcnt_q;
  logic [2:0]  rx_bit_q;
  logic [7:0]  rx_sh_q;
  logic        rx_done_q, rx_fe_q;
  logic        rx_s, rx_fall, rx_tick, rx_bit_end, rx_on;

  // rx_sync_q[1] is the synchronized line; [2] only serves edge detection.
  assign rx_s       = rx_sync_q[1];
  assign rx_fall    = rx_sync_q[2] & ~rx_sync_q[1];
  assign rx_tick    = (rx_pres_q >= pr_i);
  assign rx_bit_end = rx_tick && (rx_tcnt_q == 4'd15);
  assign rx_on      = en_i & rxen_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) rx_sync_q <= 3'b111;
    else         rx_sync_q <= {rx_sync_q[1:0], rx_i};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || !rx_on) begin
      rx_st_q   <= S_IDLE;
      rx_done_q <= 1'b0;
      rx_fe_q   <= 1'b0;
      rx_pres_q <= '0;
      rx_tcnt_q <= '0;
      rx_bit_q  <= '0;
    end else begin
      rx_done_q <= 1'b0;
      rx_fe_q   <= 1'b0;
      rx_pres_q <= (rx_st_q == S_IDLE || rx_tick) ? 16'd0 : rx_pres_q + 16'd1;
      if (rx_st_q != S_IDLE && rx_tick) rx_tcnt_q <= rx_tcnt_q + 4'd1;
      case (rx_st_q)
        S_IDLE: begin
          if (rx_fall) begin
            rx_st_q   <= S_START;
            rx_tcnt_q <= '0;
          end
        end
        S_START: begin
          // Eighth tick is mid start bit; a high line here means a glitch.
          if (rx_tick && rx_tcnt_q == 4'd7) begin
            if (rx_s) begin
              rx_st_q <= S_IDLE;
            end else begin
              rx_st_q   <= S_DATA;
              rx_tcnt_q <= '0;
              rx_bit_q  <= '0;
            end
          end
        end
        S_DATA: begin
          if (rx_bit_end) begin
            rx_sh_q  <= {rx_s, rx_sh_q[7:1]};
            rx_bit_q <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_st_q <= S_STOP;
          end
        end
        S_STOP: begin
          if (rx_bit_end) begin
            if (rx_s) rx_done_q <= 1'b1;
            else      rx_fe_q   <= 1'b1;
            rx_st_q <= S_IDLE;
          end
        end
        default: rx_st_q <= S_IDLE;
      endcase
    end
  end

  assign rx_done   = rx_done_q;
  assign rx_fe_o   = rx_fe_q;
  assign rx_data_o = rx_sh_q;
endmodule

module uart_apb (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic [31:0] PADDR,
  input  logic        PWRITE,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        IRQ,
  input  logic        rx,
  output logic        tx
);
  localparam logic [7:0] A_RXDATA = 8'h00, A_TXDATA = 8'h04, A_PR    = 8'h08,
                         A_CTRL   = 8'h0C, A_TXLVL  = 8'h10, A_RXLVL = 8'h14,
                         A_IM     = 8'h30, A_MIS    = 8'h34, A_RIS   = 8'h38,
                         A_IC     = 8'h3C;

  logic [7:0]  addr;
  logic        wr_en, rd_en;
  logic [15:0] pr_q, pr_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [5:0]  im_q, im_d, ris_q, ris_d, ris_set, ris_clr;
  logic        irq_q;
  logic [4:0]  tx_lvl, rx_lvl;
  logic [7:0]  tx_head, rx_head, rx_byte;
  logic        tx_pop, tx_done_w, rx_done_w, rx_fe, rx_pop, rx_ovr;
  logic        unused_bits;

  assign addr        = PADDR[7:0];
  assign wr_en       = PSEL & PENABLE & PWRITE;
  assign rd_en       = PSEL & PENABLE & ~PWRITE;
  assign unused_bits = ^{PADDR[31:8], PWDATA[31:16]};

  assign rx_pop = rd_en && (addr == A_RXDATA);
  assign rx_ovr = rx_done_w && (rx_lvl == 5'd16) && !rx_pop;

  uart_fifo u_txf (
    .clk_i   (PCLK),
    .rst_ni  (PRESETn),
    .push_i  (wr_en && (addr == A_TXDATA)),
    .pop_i   (tx_pop),
    .wdata_i (PWDATA[7:0]),
    .rdata_o (tx_head),
    .level_o (tx_lvl)
  );

  uart_fifo u_rxf (
    .clk_i   (PCLK),
    .rst_ni  (PRESETn),
    .push_i  (rx_done_w),
    .pop_i   (rx_pop),
    .wdata_i (rx_byte),
    .rdata_o (rx_head),
    .level_o (rx_lvl)
  );

  uart_core instance_to_wrap (
    .clk_i      (PCLK),
    .rst_ni     (PRESETn),
    .en_i       (ctrl_q[0]),
    .txen_i     (ctrl_q[1]),
    .rxen_i     (ctrl_q[2]),
    .pr_i       (pr_q),
    .tx_empty_i (tx_lvl == 5'd0),
    .tx_data_i  (tx_head),
    .rx_i       (rx),
    .tx_o       (tx),
    .tx_pop_o   (tx_pop),
    .tx_done    (tx_done_w),
    .rx_done    (rx_done_w),
    .rx_fe_o    (rx_fe),
    .rx_data_o  (rx_byte)
  );

  // Set wins over a same-cycle clear, so a still-true level condition survives IC.
  always_comb begin
    ris_set = {rx_ovr, rx_fe, rx_done_w & ~rx_ovr, tx_done_w, rx_lvl != 5'd0, tx_lvl == 5'd0};
    ris_clr = (wr_en && addr == A_IC) ? PWDATA[5:0] : 6'd0;
    ris_d   = (ris_q & ~ris_clr) | ris_set;
    pr_d    = (wr_en && addr == A_PR)   ? PWDATA[15:0] : pr_q;
    ctrl_d  = (wr_en && addr == A_CTRL) ? PWDATA[2:0]  : ctrl_q;
    im_d    = (wr_en && addr == A_IM)   ? PWDATA[5:0]  : im_q;
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      pr_q   <= '0;
      ctrl_q <= '0;
      im_q   <= '0;
      ris_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      pr_q   <= pr_d;
      ctrl_q <= ctrl_d;
      im_q   <= im_d;
      ris_q  <= ris_d;
      irq_q  <= |(ris_q & im_q);
    end
  end

  always_comb begin
    PRDATA = '0;
    case (addr)
      A_RXDATA: PRDATA = {24'd0, (rx_lvl == 5'd0) ? 8'd0 : rx_head};
      A_PR:     PRDATA = {16'd0, pr_q};
      A_CTRL:   PRDATA = {29'd0, ctrl_q};
      A_TXLVL:  PRDATA = {27'd0, tx_lvl};
      A_RXLVL:  PRDATA = {27'd0, rx_lvl};
      A_IM:     PRDATA = {26'd0, im_q};
      A_MIS:    PRDATA = {26'd0, ris_q & im_q};
      A_RIS:    PRDATA = {26'd0, ris_q};
      default:  PRDATA = '0;
    endcase
  end

  assign PREADY = 1'b1;
  assign IRQ    = irq_q;
endmodule

// File: tb/tb_uart_apb.sv
// Directed bench for uart_apb: register reset values, loopback framing,
// FIFO fill/drain ordering, framing error, overrun, glitch rejection, disable.

module tb_uart_apb;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] PADDR = '0;
  logic        PWRITE = 1'b0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, IRQ, tx;
  logic        rx_drv = 1'b1;
  logic        loop = 1'b0;
  logic        rx_line;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] rd;

  assign rx_line = loop ? tx : rx_drv;

  uart_apb dut (
    .PCLK    (clk),
    .PRESETn (rst_n),
    .PADDR   (PADDR),
    .PWRITE  (PWRITE),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .IRQ     (IRQ),
    .rx      (rx_line),
    .tx      (tx)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    PADDR = {24'd0, a}; PWDATA = d; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
    cycles(1);
    PENABLE = 1'b1;
    cycles(1);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
    PADDR = {24'd0, a}; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
    cycles(1);
    PENABLE = 1'b1;
    #2 d = PRDATA;
    cycles(1);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx_drv = 1'b0;
    cycles(16);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      cycles(16);
    end
    rx_drv = stop;
    cycles(16);
    rx_drv = 1'b1;
    cycles(4);
  endtask

  task automatic test_reset;
    logic [7:0]  addrs [11];
    logic [31:0] exps  [11];
    addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h30, 8'h34, 8'h38, 8'h3C, 8'h40};
    exps  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1, 32'h0, 32'h0};
    rst_n = 1'b0;
    cycles(5);
    rst_n = 1'b1;
    cycles(2);
    checks++;
    if (tx !== 1'b1 || IRQ !== 1'b0 || PREADY !== 1'b1) begin
      errors++;
      $display("FAIL reset_pins: tx=%b IRQ=%b PREADY=%b, required 1 0 1", tx, IRQ, PREADY);
    end
    for (int i = 0; i < 11; i++) begin
      apb_read(addrs[i], rd);
      checks++;
      if (rd !== exps[i]) begin
        errors++;
        $display("FAIL reset_reg_%02h: got %08h, required %08h", addrs[i], rd, exps[i]);
      end
    end
  endtask

  task automatic test_loopback;
    logic [9:0] bits;
    int t, rx_t;
    logic seen;
    bits = {1'b1, 8'hA5, 1'b0};
    loop = 1'b1;
    apb_write(8'h08, 32'd0);
    apb_write(8'h0C, 32'h7);
    apb_write(8'h04, 32'hA5);
    t = 0;
    while (tx !== 1'b0 && t < 10) begin
      cycles(1);
      t++;
    end
    checks++;
    if (tx !== 1'b0 || t > 3) begin
      errors++;
      $display("FAIL tx_start_latency: %0d clocks (tx=%b), required <= 3", t, tx);
    end
    t = 0;
    for (int k = 0; k < 10; k++) begin
      cycles(k == 0 ? 8 : 16);
      t += (k == 0) ? 8 : 16;
      checks++;
      if (tx !== bits[k]) begin
        errors++;
        $display("FAIL loop_bit%0d: tx=%b, required %b", k, tx, bits[k]);
      end
    end
    rx_t = -1;
    seen = 1'b0;
    while (!seen && t < 400) begin
      cycles(1);
      t++;
      if (dut.instance_to_wrap.rx_done) rx_t = t;
      if (dut.instance_to_wrap.tx_done) seen = 1'b1;
    end
    checks++;
    if (!seen || t != 160) begin
      errors++;
      $display("FAIL tx_done_time: at %0d clocks (seen=%b), required 160", t, seen);
    end
    checks++;
    if (rx_t < 153 || rx_t > 155) begin
      errors++;
      $display("FAIL rx_done_time: at %0d clocks, required 153..155", rx_t);
    end
    cycles(2);
    apb_read(8'h14, rd);
    checks++;
    if (rd !== 32'd1) begin errors++; $display("FAIL loop_rxlvl1: got %0d, required 1", rd); end
    apb_read(8'h00, rd);
    checks++;
    if (rd !== 32'hA5) begin errors++; $display("FAIL loop_rxdata: got %02h, required a5", rd); end
    apb_read(8'h14, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL loop_rxlvl0: got %0d, required 0", rd); end
  endtask

  task automatic test_fifo_fill;
    int t, n, last;
    loop = 1'b1;
    apb_write(8'h0C, 32'h0);
    apb_write(8'h3C, 32'h3F);
    for (int i = 0; i < 17; i++) apb_write(8'h04, 32'h10 + i);
    apb_read(8'h10, rd);
    checks++;
    if (rd !== 32'd16) begin errors++; $display("FAIL fill_txlvl: got %0d, required 16", rd); end
    apb_write(8'h08, 32'd1);
    apb_write(8'h0C, 32'h7);
    t = 0; n = 0; last = 0;
    while (n < 16 && t < 6000) begin
      cycles(1);
      t++;
      if (dut.instance_to_wrap.tx_done) begin
        if (n > 0) begin
          checks++;
          if (t - last != 320) begin
            errors++;
            $display("FAIL frame_period%0d: %0d clocks, required 320", n, t - last);
          end
        end
        last = t;
        n++;
      end
    end
    checks++;
    if (n != 16) begin errors++; $display("FAIL fill_frames: got %0d tx_done, required 16", n); end
    cycles(700);
    apb_read(8'h10, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL drain_txlvl: got %0d, required 0", rd); end
    apb_read(8'h14, rd);
    checks++;
    if (rd !== 32'd16) begin errors++; $display("FAIL drain_rxlvl: got %0d, required 16", rd); end
    apb_read(8'h38, rd);
    checks++;
    if (rd[5] !== 1'b0) begin errors++; $display("FAIL drain_no_overrun: RIS=%02h, required bit5=0", rd); end
    for (int i = 0; i < 16; i++) begin
      apb_read(8'h00, rd);
      checks++;
      if (rd !== 32'h10 + i) begin
        errors++;
        $display("FAIL fill_order%0d: got %02h, required %02h", i, rd, 8'h10 + i);
      end
    end
    loop = 1'b0;
    apb_write(8'h08, 32'd0);
  endtask

  task automatic test_disable;
    apb_write(8'h0C, 32'h7);
    apb_write(8'h04, 32'h00);
    cycles(30);
    checks++;
    if (tx !== 1'b0) begin errors++; $display("FAIL disable_midframe: tx=%b, required 0", tx); end
    apb_write(8'h0C, 32'h0);
    cycles(1);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL disable_tx_high: tx=%b, required 1", tx); end
    apb_read(8'h10, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL disable_txlvl: got %0d, required 0", rd); end
    apb_write(8'h0C, 32'h7);
  endtask

  task automatic test_framing;
    apb_write(8'h3C, 32'h3F);
    apb_write(8'h30, 32'h10);
    send_frame(8'h3C, 1'b0);
    apb_read(8'h38, rd);
    checks++;
    if (rd[4] !== 1'b1) begin errors++; $display("FAIL fe_set: RIS=%02h, required bit4=1", rd); end
    apb_read(8'h34, rd);
    checks++;
    if (rd !== 32'h10) begin errors++; $display("FAIL fe_mis: got %02h, required 10", rd); end
    checks++;
    if (IRQ !== 1'b1) begin errors++; $display("FAIL fe_irq: IRQ=%b, required 1", IRQ); end
    apb_read(8'h14, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL fe_rxlvl: got %0d, required 0", rd); end
    apb_write(8'h3C, 32'h10);
    checks++;
    if (IRQ !== 1'b1) begin errors++; $display("FAIL ic_irq_lag: IRQ=%b, required 1 for one more clock", IRQ); end
    cycles(1);
    checks++;
    if (IRQ !== 1'b0) begin errors++; $display("FAIL ic_irq_clear: IRQ=%b, required 0", IRQ); end
    apb_read(8'h38, rd);
    checks++;
    if (rd[4] !== 1'b0) begin errors++; $display("FAIL ic_ris: RIS=%02h, required bit4=0", rd); end
    apb_write(8'h30, 32'h0);
  endtask

  task automatic test_overrun;
    apb_write(8'h3C, 32'h3F);
    for (int i = 0; i < 17; i++) send_frame(8'h40 + i[7:0], 1'b1);
    apb_read(8'h14, rd);
    checks++;
    if (rd !== 32'd16) begin errors++; $display("FAIL ovr_rxlvl: got %0d, required 16", rd); end
    apb_read(8'h38, rd);
    checks++;
    if (rd[5] !== 1'b1 || rd[3] !== 1'b1) begin
      errors++;
      $display("FAIL ovr_flags: RIS=%02h, required bits 5 and 3 set", rd);
    end
    for (int i = 0; i < 16; i++) begin
      apb_read(8'h00, rd);
      checks++;
      if (rd !== 32'h40 + i) begin
        errors++;
        $display("FAIL ovr_data%0d: got %02h, required %02h", i, rd, 8'h40 + i);
      end
    end
    apb_read(8'h00, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL empty_read: got %02h, required 0", rd); end
  endtask

  task automatic test_glitch;
    int hits;
    apb_write(8'h3C, 32'h3F);
    hits = 0;
    rx_drv = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (i == 4) rx_drv = 1'b1;
      cycles(1);
      if (dut.instance_to_wrap.rx_done || dut.instance_to_wrap.rx_fe_o) hits++;
    end
    checks++;
    if (hits != 0) begin errors++; $display("FAIL glitch_events: %0d events, required 0", hits); end
    apb_read(8'h38, rd);
    checks++;
    if (rd !== 32'h01) begin errors++; $display("FAIL glitch_ris: got %02h, required 01", rd); end
    apb_read(8'h14, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL glitch_rxlvl: got %0d, required 0", rd); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_fifo_fill();
    test_disable();
    test_framing();
    test_overrun();
    test_glitch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
